// File: rtl/sap_clk_pkg.sv
// Shared types and default auto-run divider constants for the SAP-1 clock controller.
// Default terminal counts assume a 50 MHz system clock.
package sap_clk_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef logic [1:0] speed_t;

  localparam int unsigned DIV_WIDTH_DEF = 26;
  localparam int unsigned DIV0_DEF      = 49_999_999;  // 1 Hz
  localparam int unsigned DIV1_DEF      = 12_499_999;  // 4 Hz
  localparam int unsigned DIV2_DEF      = 2_499_999;   // 20 Hz
  localparam int unsigned DIV3_DEF      = 49_999;      // 1 kHz

endpackage

// File: rtl/sap_clock_ctrl_if.sv
// Front-panel / datapath signals of the SAP-1 clock controller.
// The master side drives the button pulses, HLT and speed; the slave side is the controller.
interface sap_clock_ctrl_if;
  import sap_clk_pkg::*;

  logic   step_pb;
  logic   mode_pb;
  logic   hlt;
  speed_t speed;
  logic   cpu_en;
  logic   cpu_clk_led;
  logic   auto_led;
  logic   halt_led;

  modport master (
    output step_pb, mode_pb, hlt, speed,
    input  cpu_en, cpu_clk_led, auto_led, halt_led
  );

  modport slave (
    input  step_pb, mode_pb, hlt, speed,
    output cpu_en, cpu_clk_led, auto_led, halt_led
  );

endinterface

// File: rtl/clk_divider.sv
// Auto-run tick generator: counts while enabled and ticks once the count reaches the terminal.
// A >= compare means lowering the terminal mid-count ticks on the next cycle instead of wrapping.
module clk_divider #(
  parameter int unsigned DIV_WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sclr,
  input  logic [DIV_WIDTH-1:0] term,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count;

  assign tick = en && !sclr && (count >= term);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (!en || sclr || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sap_clock_ctrl.sv
// SAP-1 clock controller: turns step presses or an auto-run divider into a one-cycle cpu_en,
// honours HLT until the next clr, and drives the clock/auto/halt status LEDs.
module sap_clock_ctrl
  import sap_clk_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int unsigned DIV0      = DIV0_DEF,
  parameter int unsigned DIV1      = DIV1_DEF,
  parameter int unsigned DIV2      = DIV2_DEF,
  parameter int unsigned DIV3      = DIV3_DEF
) (
  input  logic            clk,
  input  logic            clr,
  sap_clock_ctrl_if.slave bus
);

  localparam longint unsigned DIV_LIMIT = 64'd1 << DIV_WIDTH;

  if (DIV0 >= DIV_LIMIT || DIV1 >= DIV_LIMIT || DIV2 >= DIV_LIMIT || DIV3 >= DIV_LIMIT)
  begin : g_div_range_check
    $error("sap_clock_ctrl: every DIVx terminal count must fit in DIV_WIDTH bits");
  end

  state_t               state;
  logic                 cpu_en_q;
  logic                 cpu_clk_led_q;
  logic                 auto_led_q;
  logic                 halt_led_q;
  logic [DIV_WIDTH-1:0] term;
  logic                 tick;
  logic                 manual_step;
  logic                 fire;

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    term = DIV_WIDTH'(DIV0);
    case (bus.speed)
      2'd1:    term = DIV_WIDTH'(DIV1);
      2'd2:    term = DIV_WIDTH'(DIV2);
      2'd3:    term = DIV_WIDTH'(DIV3);
      default: term = DIV_WIDTH'(DIV0);
    endcase
  end

  // hlt and mode_pb both clear the counter and swallow a coinciding tick.
  clk_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .clk  (clk),
    .clr  (clr),
    .en   (state == AUTO),
    .sclr (bus.hlt || bus.mode_pb),
    .term (term),
    .tick (tick)
  );

  assign manual_step = (state == MANUAL) && bus.step_pb && !bus.mode_pb && !bus.hlt;
  assign fire        = manual_step || tick;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= MANUAL;
      cpu_en_q      <= 1'b0;
      cpu_clk_led_q <= 1'b0;
      auto_led_q    <= 1'b0;
      halt_led_q    <= 1'b0;
    end else begin
      cpu_en_q      <= fire;
      cpu_clk_led_q <= cpu_clk_led_q ^ fire;
      case (state)
        MANUAL: begin
          if (bus.hlt) begin
            state      <= HALTED;
            halt_led_q <= 1'b1;
          end else if (bus.mode_pb) begin
            state      <= AUTO;
            auto_led_q <= 1'b1;
          end
        end
        AUTO: begin
          if (bus.hlt) begin
            state      <= HALTED;
            auto_led_q <= 1'b0;
            halt_led_q <= 1'b1;
          end else if (bus.mode_pb) begin
            state      <= MANUAL;
            auto_led_q <= 1'b0;
          end
        end
        HALTED: begin
          // Only clr leaves HALTED; the SAP-1 must be reset after HLT.
          state <= HALTED;
        end
        default: begin
          state      <= MANUAL;
          auto_led_q <= 1'b0;
          halt_led_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.cpu_clk_led = cpu_clk_led_q;
  assign bus.auto_led    = auto_led_q;
  assign bus.halt_led    = halt_led_q;

endmodule

// File: tb/tb_sap_clock_ctrl.sv
// Directed bench for sap_clock_ctrl with short terminal counts (DIV0=3, DIV1=7, DIV2=1, DIV3=0).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sap_clock_ctrl;
  import sap_clk_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic led_exp = 1'b0;

  sap_clock_ctrl_if bus ();

  sap_clock_ctrl #(
    .DIV_WIDTH (26),
    .DIV0      (3),
    .DIV1      (7),
    .DIV2      (1),
    .DIV3      (0)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.step_pb = 1'b0;
    bus.mode_pb = 1'b0;
    bus.hlt     = 1'b0;
  endtask

  task automatic apply_reset();
    clr = 1'b0;
    idle_inputs();
    tick();
    tick();
    clr     = 1'b1;
    led_exp = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0;
    idle_inputs();
    bus.speed   = 2'd0;
    bus.step_pb = 1'b1;
    tick();
    tick();
    bus.step_pb = 1'b0;
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL reset cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.cpu_clk_led !== 1'b0) begin errors++; $display("FAIL reset cpu_clk_led: got %b expected 0", bus.cpu_clk_led); end
    checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL reset auto_led: got %b expected 0", bus.auto_led); end
    checks++; if (bus.halt_led !== 1'b0) begin errors++; $display("FAIL reset halt_led: got %b expected 0", bus.halt_led); end
  endtask

  task automatic test_single_step();
    clr     = 1'b1;
    led_exp = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL step idle c=%0d cpu_en: got %b expected 0", c, bus.cpu_en); end
    end
    bus.step_pb = 1'b1;
    tick();
    bus.step_pb = 1'b0;
    led_exp = 1'b1;
    checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL step pulse cpu_en: got %b expected 1", bus.cpu_en); end
    checks++; if (bus.cpu_clk_led !== 1'b1) begin errors++; $display("FAIL step pulse cpu_clk_led: got %b expected 1", bus.cpu_clk_led); end
    checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL step pulse auto_led: got %b expected 0", bus.auto_led); end
    tick();
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL step after cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.cpu_clk_led !== 1'b1) begin errors++; $display("FAIL step after cpu_clk_led: got %b expected 1", bus.cpu_clk_led); end
    // Back-to-back presses must each produce a pulse.
    bus.step_pb = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      led_exp = ~led_exp;
      checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL step b2b c=%0d cpu_en: got %b expected 1", c, bus.cpu_en); end
      checks++; if (bus.cpu_clk_led !== led_exp) begin errors++; $display("FAIL step b2b c=%0d cpu_clk_led: got %b expected %b", c, bus.cpu_clk_led, led_exp); end
    end
    bus.step_pb = 1'b0;
    tick();
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL step b2b end cpu_en: got %b expected 0", bus.cpu_en); end
  endtask

  task automatic test_auto_rate();
    int   pulses;
    logic exp_en;
    pulses      = 0;
    bus.speed   = 2'd0;
    bus.mode_pb = 1'b1;
    tick();
    bus.mode_pb = 1'b0;
    checks++; if (bus.auto_led !== 1'b1) begin errors++; $display("FAIL auto enter auto_led: got %b expected 1", bus.auto_led); end
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL auto enter cpu_en: got %b expected 0", bus.cpu_en); end
    for (int k = 1; k <= 20; k++) begin
      bus.step_pb = (k == 2 || k == 5 || k == 8);
      tick();
      bus.step_pb = 1'b0;
      exp_en = (k % 4 == 0);
      if (exp_en) led_exp = ~led_exp;
      if (bus.cpu_en === 1'b1) pulses++;
      checks++; if (bus.cpu_en !== exp_en) begin errors++; $display("FAIL auto speed0 k=%0d cpu_en: got %b expected %b", k, bus.cpu_en, exp_en); end
      checks++; if (bus.cpu_clk_led !== led_exp) begin errors++; $display("FAIL auto speed0 k=%0d cpu_clk_led: got %b expected %b", k, bus.cpu_clk_led, led_exp); end
    end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL auto speed0 pulse count: got %0d expected 5", pulses); end
    bus.speed = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      led_exp = ~led_exp;
      checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL auto speed3 k=%0d cpu_en: got %b expected 1", k, bus.cpu_en); end
      checks++; if (bus.cpu_clk_led !== led_exp) begin errors++; $display("FAIL auto speed3 k=%0d cpu_clk_led: got %b expected %b", k, bus.cpu_clk_led, led_exp); end
    end
  endtask

  task automatic test_speed_change();
    logic exp_en;
    // Counter is 0 here; with speed 1 it reaches 6 after six edges.
    bus.speed = 2'd1;
    for (int j = 1; j <= 12; j++) begin
      if (j == 7) bus.speed = 2'd2;
      tick();
      exp_en = (j >= 7) && (j % 2 == 1);
      if (exp_en) led_exp = ~led_exp;
      checks++; if (bus.cpu_en !== exp_en) begin errors++; $display("FAIL speed change j=%0d cpu_en: got %b expected %b", j, bus.cpu_en, exp_en); end
      checks++; if (bus.cpu_clk_led !== led_exp) begin errors++; $display("FAIL speed change j=%0d cpu_clk_led: got %b expected %b", j, bus.cpu_clk_led, led_exp); end
    end
  endtask

  task automatic test_halt_precedence();
    apply_reset();
    bus.speed   = 2'd0;
    bus.mode_pb = 1'b1;
    tick();
    bus.mode_pb = 1'b0;
    tick();
    tick();
    tick();
    // Counter now sits at its terminal (3); hlt must win over the tick.
    bus.hlt = 1'b1;
    tick();
    bus.hlt = 1'b0;
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL halt entry cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.halt_led !== 1'b1) begin errors++; $display("FAIL halt entry halt_led: got %b expected 1", bus.halt_led); end
    checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL halt entry auto_led: got %b expected 0", bus.auto_led); end
    checks++; if (bus.cpu_clk_led !== 1'b0) begin errors++; $display("FAIL halt entry cpu_clk_led: got %b expected 0", bus.cpu_clk_led); end
    for (int k = 1; k <= 6; k++) begin
      bus.step_pb = (k == 1 || k == 4);
      bus.mode_pb = (k == 2 || k == 5);
      bus.speed   = speed_t'(k);
      tick();
      idle_inputs();
      checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL halted k=%0d cpu_en: got %b expected 0", k, bus.cpu_en); end
      checks++; if (bus.halt_led !== 1'b1) begin errors++; $display("FAIL halted k=%0d halt_led: got %b expected 1", k, bus.halt_led); end
      checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL halted k=%0d auto_led: got %b expected 0", k, bus.auto_led); end
    end
    clr = 1'b0;
    #1;
    checks++; if (bus.halt_led !== 1'b0) begin errors++; $display("FAIL halt clr halt_led: got %b expected 0", bus.halt_led); end
    tick();
    clr       = 1'b1;
    led_exp   = 1'b0;
    bus.speed = 2'd0;
    tick();
    bus.step_pb = 1'b1;
    tick();
    bus.step_pb = 1'b0;
    checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL halt exit step cpu_en: got %b expected 1", bus.cpu_en); end
    checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL halt exit auto_led: got %b expected 0", bus.auto_led); end
    checks++; if (bus.halt_led !== 1'b0) begin errors++; $display("FAIL halt exit halt_led: got %b expected 0", bus.halt_led); end
  endtask

  task automatic test_mode_and_step();
    logic exp_en;
    apply_reset();
    bus.speed   = 2'd0;
    bus.mode_pb = 1'b1;
    bus.step_pb = 1'b1;
    tick();
    idle_inputs();
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL mode+step cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.auto_led !== 1'b1) begin errors++; $display("FAIL mode+step auto_led: got %b expected 1", bus.auto_led); end
    for (int j = 1; j <= 4; j++) begin
      tick();
      exp_en = (j == 4);
      if (exp_en) led_exp = ~led_exp;
      checks++; if (bus.cpu_en !== exp_en) begin errors++; $display("FAIL mode+step j=%0d cpu_en: got %b expected %b", j, bus.cpu_en, exp_en); end
    end
    checks++; if (bus.cpu_clk_led !== led_exp) begin errors++; $display("FAIL mode+step cpu_clk_led: got %b expected %b", bus.cpu_clk_led, led_exp); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.speed   = 2'd0;
    bus.step_pb = 1'b1;
    tick();
    bus.step_pb = 1'b0;
    bus.mode_pb = 1'b1;
    tick();
    bus.mode_pb = 1'b0;
    tick();
    tick();
    // AUTO with the counter at 2 and the clock LED lit.
    checks++; if (bus.auto_led !== 1'b1) begin errors++; $display("FAIL mid pre auto_led: got %b expected 1", bus.auto_led); end
    checks++; if (bus.cpu_clk_led !== 1'b1) begin errors++; $display("FAIL mid pre cpu_clk_led: got %b expected 1", bus.cpu_clk_led); end
    #2;
    clr = 1'b0;
    #1;
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL mid clr cpu_en: got %b expected 0", bus.cpu_en); end
    checks++; if (bus.cpu_clk_led !== 1'b0) begin errors++; $display("FAIL mid clr cpu_clk_led: got %b expected 0", bus.cpu_clk_led); end
    checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL mid clr auto_led: got %b expected 0", bus.auto_led); end
    checks++; if (bus.halt_led !== 1'b0) begin errors++; $display("FAIL mid clr halt_led: got %b expected 0", bus.halt_led); end
    tick();
    clr = 1'b1;
    tick();
    checks++; if (bus.auto_led !== 1'b0) begin errors++; $display("FAIL mid release auto_led: got %b expected 0", bus.auto_led); end
    checks++; if (bus.cpu_en !== 1'b0) begin errors++; $display("FAIL mid release cpu_en: got %b expected 0", bus.cpu_en); end
    bus.step_pb = 1'b1;
    tick();
    bus.step_pb = 1'b0;
    checks++; if (bus.cpu_en !== 1'b1) begin errors++; $display("FAIL mid release step cpu_en: got %b expected 1", bus.cpu_en); end
  endtask

  initial begin
    idle_inputs();
    bus.speed = 2'd0;
    test_reset();
    test_single_step();
    test_auto_rate();
    test_speed_change();
    test_halt_precedence();
    test_mode_and_step();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_clock_ctrl.md
Name: sap_clock_ctrl

Overview:
- Clock controller for the SAP-1 FPGA build. It sits directly downstream of the push-button debouncers and consumes their single-cycle press pulses.
- It produces a one-cycle clock-enable, `cpu_en`, that advances the SAP-1 datapath. The enable comes either from manual single-step presses or from a selectable auto-run divider.
- It honours the SAP-1 HLT control signal and also drives status LEDs.

Parameters:
- DIV_WIDTH, 26, width of the auto-run tick counter.
- DIV0, 49_999_999, terminal count for speed 0 (1 Hz at 50 MHz).
- DIV1, 12_499_999, terminal count for speed 1 (4 Hz).
- DIV2, 2_499_999, terminal count for speed 2 (20 Hz).
- DIV3, 49_999, terminal count for speed 3 (1 kHz).

Ports:
- clk  in  1  system clock.
- clr  in  1  asynchronous, active-low reset.
- step_pb  in  1  single-cycle pulse from the step-button debouncer (PB_down).
- mode_pb  in  1  single-cycle pulse from the mode-button debouncer; toggles manual/auto.
- hlt  in  1  SAP-1 HLT control line; level, active high.
- speed  in  2  auto-run rate select (DIV0..DIV3).
- cpu_en  out  1  one-cycle datapath clock enable.
- cpu_clk_led  out  1  toggles on every cpu_en; drives the visible clock LED.
- auto_led  out  1  high while in AUTO.
- halt_led  out  1  high while in HALTED.

Behaviour:
- Reset: clr low asynchronously forces the following. Reset applies mid-count and in any state; no cpu_en is issued while clr is low.
  - state = MANUAL
  - tick counter = 0
  - cpu_en = 0
  - cpu_clk_led = 0
  - auto_led = 0
  - halt_led = 0
- All outputs are registered.
- States: MANUAL, AUTO, HALTED.
- Priority each cycle: hlt > mode_pb > step_pb / terminal count.
- MANUAL:
  - step_pb high in cycle N gives cpu_en high in cycle N+1 only (one cycle).
  - mode_pb moves to AUTO and clears the counter.
  - The counter is held at 0.
- AUTO:
  - The counter increments every cycle.
  - When counter >= DIVsel (selected by the current speed): cpu_en is high the next cycle and the counter returns to 0. The period is DIVsel+1 cycles.
  - Using >= rather than == guarantees no wrap when speed is lowered mid-count: the pulse fires on the next cycle.
  - step_pb is ignored.
  - mode_pb moves to MANUAL, clears the counter and suppresses any pulse that would have issued that cycle.
- HALTED:
  - Entered from MANUAL or AUTO in the cycle after hlt is sampled high.
  - No cpu_en is issued in the entering cycle, even if step_pb or the terminal count coincide.
  - step_pb, mode_pb and speed are ignored.
  - Exit is by clr only, because the SAP-1 must be reset after HLT.
- Simultaneous events:
  - mode_pb and step_pb in MANUAL: the mode switch happens and no pulse issues.
  - hlt together with anything: HALTED, no pulse.
- cpu_clk_led toggles in the same cycle that cpu_en is high.
- auto_led = (state == AUTO); halt_led = (state == HALTED).
- Arithmetic: the counter is unsigned DIV_WIDTH bits. DIV0..DIV3 must each fit in DIV_WIDTH, and this is checked by an elaboration-time assertion. The counter never exceeds max(DIVx).
- Consecutive manual pulses: step_pb on every cycle gives cpu_en on every cycle. The debouncer makes this physically impossible, but the block must not drop pulses.

Decomposition:
- Package sap_clk_pkg:
  - state enum type (MANUAL, AUTO, HALTED), 2-bit encoding.
  - speed select typedef (2-bit).
  - default DIV constants.
- Sub-module clk_divider:
  - Parameterised DIV_WIDTH.
  - Inputs: enable, sync clear, terminal value.
  - Output: one-cycle tick.
  - Counter and >= compare live here.
- The FSM, priority logic and LEDs stay in sap_clock_ctrl.

Test Plan (bench overrides DIV0=3, DIV1=7, DIV2=1, DIV3=0):
- Reset then single step: release clr, pulse step_pb at cycle 5 -> cpu_en high only at cycle 6; cpu_clk_led 0->1 at cycle 6; auto_led=0.
- Auto rate: mode_pb pulse, speed=0 -> cpu_en every 4 cycles, and exactly 5 pulses in 20 cycles; step_pb pulses during AUTO cause no extra cpu_en; speed=3 -> cpu_en every cycle.
- Speed lowered mid-count: speed=1, counter reaches 6, switch speed to 2 -> cpu_en next cycle, then every 2 cycles; no 2^26 wrap.
- Halt precedence: in AUTO, assert hlt in the same cycle the counter hits its terminal -> no cpu_en, halt_led=1 next cycle; later step_pb and mode_pb give no cpu_en and no state change; clr low then high -> MANUAL, halt_led=0.
- Simultaneous mode and step in MANUAL: both pulse in the same cycle -> AUTO entered, no cpu_en that cycle; first auto pulse DIVsel+1 cycles later.
- Reset mid-operation: in AUTO with counter=2, drop clr asynchronously between edges -> all outputs 0 immediately; after release, MANUAL with counter 0.
